booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `booth_multiplier` instance among `NUM_REQ` requesters. It accepts operand pairs over a valid/ready handshake and issues each pair to the multiplier as a one-cycle `valid_in` pulse. It waits for the multiplier's `valid_out`, then returns the product tagged with the requester index. It sits between client blocks and the multiplier, so the multiplier is never driven by more than one requester and never has more than one operation in flight.

---
 rtl/booth_mul_arbiter.sv | 156 +++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin arbiter and sequencer that shares one booth_multiplier
// among NUM_REQ requesters. It keeps at most one operation in flight and returns each
// product tagged with the index of the requester that owns it.
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to build the WAIT-state watchdog,
// which raises rsp_error when the multiplier does not answer within TIMEOUT_CYCLES.
module booth_mul_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WIDTH_INPUT    = 16,
    parameter int unsigned WIDTH_OUTPUT   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WIDTH_INPUT-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_INPUT-1:0]   req_b,
    output logic                             rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [WIDTH_OUTPUT-1:0]          rsp_product,
    output logic                             rsp_error,
    output logic                             busy,
    output logic [WIDTH_INPUT-1:0]           mul_in_a,
    output logic [WIDTH_INPUT-1:0]           mul_in_b,
    output logic                             mul_valid_in,
    input  logic                             mul_valid_out,
    input  logic [WIDTH_OUTPUT-1:0]          mul_product
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic              vo_q;
    logic              mul_rise;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;

    // Parameter sanity: at least two requesters and a non-zero watchdog limit
    if (NUM_REQ < 2 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("booth_mul_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES > 0");
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  wait_cnt;
`else
    // Without the watchdog there is no error source
    assign rsp_error = 1'b0;
`endif

    // A level left high by the previous operation must not look like completion
    assign mul_rise = mul_valid_out & ~vo_q;

    // Round-robin search starting one past the last granted index
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Accept is combinational and only offered in IDLE, never while reset is held
    always_comb begin
        req_ready = '0;
        if (reset && (state == ST_IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer: grant, issue one pulse, wait for a fresh completion edge, respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ptr          <= ID_W'(NUM_REQ - 1);
            vo_q         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_product  <= '0;
            busy         <= 1'b0;
            mul_in_a     <= '0;
            mul_in_b     <= '0;
            mul_valid_in <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            rsp_error    <= 1'b0;
`endif
        end else begin
            vo_q         <= mul_valid_out;
            mul_valid_in <= 1'b0;
            rsp_valid    <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            rsp_error    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        mul_in_a     <= req_a[32'(grant_idx)*WIDTH_INPUT +: WIDTH_INPUT];
                        mul_in_b     <= req_b[32'(grant_idx)*WIDTH_INPUT +: WIDTH_INPUT];
                        rsp_id       <= grant_idx;
                        ptr          <= grant_idx;
                        mul_valid_in <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (mul_rise) begin
                        rsp_product <= mul_product;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a mock multiplier.
// Build with BOOTH_ARB_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_booth_mul_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned WI = 16;
    localparam int unsigned WO = 32;
    localparam int unsigned TO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*WI-1:0]  req_a = '0;
    logic [NR*WI-1:0]  req_b = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [WO-1:0]     rsp_product;
    logic              rsp_error;
    logic              busy;
    logic [WI-1:0]     mul_in_a;
    logic [WI-1:0]     mul_in_b;
    logic              mul_valid_in;
    logic              mul_valid_out = 1'b0;
    logic [WO-1:0]     mul_product = '0;

    booth_mul_arbiter #(
        .NUM_REQ(NR), .WIDTH_INPUT(WI), .WIDTH_OUTPUT(WO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .rsp_error(rsp_error), .busy(busy),
        .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_valid_in(mul_valid_in),
        .mul_valid_out(mul_valid_out), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] prod;
        logic        err;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_grant[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rsp_cnt  = 0;
    int mvi_cnt  = 0;
    int rsp_cyc  = 0;
    int mvi_cyc  = 0;

    int  mock_lat   = 17;
    int  mock_hold  = 1;
    bit  mock_never = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_rsp(input int id, input logic [31:0] prod, input logic err);
        rsp_t e;
        e.id   = 2'(id);
        e.prod = prod;
        e.err  = err;
        exp_rsp.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mock multiplier: valid_out rises mock_lat cycles after valid_in, held mock_hold cycles
    initial begin
        int mk_cnt;
        int hold;
        logic [31:0] prod_l;
        mk_cnt = -1;
        hold   = 0;
        prod_l = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mul_valid_out = 1'b0;
                mul_product   = '0;
                mk_cnt        = -1;
                hold          = 0;
            end else begin
                if (mk_cnt == 0 && !mul_valid_out) begin
                    mul_valid_out = 1'b1;
                    mul_product   = prod_l;
                    hold          = mock_hold;
                    mk_cnt        = -1;
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) mul_valid_out = 1'b0;
                end
                if (mk_cnt > 0) begin
                    mk_cnt--;
                    if (mk_cnt == 0 && !mul_valid_out) begin
                        mul_valid_out = 1'b1;
                        mul_product   = prod_l;
                        hold          = mock_hold;
                        mk_cnt        = -1;
                    end
                end
                if (mul_valid_in) begin
                    prod_l = 32'(mul_in_a) * 32'(mul_in_b);
                    mk_cnt = mock_never ? -1 : mock_lat;
                end
            end
        end
    end

    // Monitor: grants and responses are compared against the scoreboard queues
    always @(negedge clk) begin
        int   g;
        int   eg;
        rsp_t e;
        if (reset) begin
            if (req_ready != '0) begin
                check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                g = -1;
                for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
                if (exp_grant.size() == 0) check("grant_unexpected", 64'(g), 64'hdead);
                else begin
                    eg = exp_grant.pop_front();
                    check("grant_idx", 64'(g), 64'(eg));
                end
            end
            if (mul_valid_in) begin
                mvi_cnt++;
                mvi_cyc = cyc;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(rsp_product), 64'hdead);
                else begin
                    e = exp_rsp.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_product", 64'(rsp_product), 64'(e.prod));
                    check("rsp_error", 64'(rsp_error), 64'(e.err));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got = 1'b0;
        req_a[i*WI +: WI] = a;
        req_b[i*WI +: WI] = b;
        req_valid[i] = 1'b1;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        check($sformatf("grant_wait_req%0d", i), 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int c = 0; c < budget && rsp_cnt < target; c++) tick(1);
        check("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 500 && busy; c++) tick(1);
        check("returns_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        tick(n);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int mvi_base;
        tick(3);
        @(negedge clk);
        check("reset_ctrl_outputs",
              64'({req_ready, rsp_valid, rsp_id, rsp_error, busy, mul_valid_in}), 64'd0);
        check("reset_data_outputs", {rsp_product, mul_in_a, mul_in_b}, 64'd0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Single request from requester 2
        exp_grant.push_back(2);
        push_rsp(2, 32'd15, 1'b0);
        base = rsp_cnt;
        mvi_base = mvi_cnt;
        send(2, 16'd3, 16'd5);
        tick(2);
        check("t1_busy_in_wait", 64'(busy), 64'd1);
        wait_rsp(base + 1, 200);
        check("t1_mvi_pulses", 64'(mvi_cnt - mvi_base), 64'd1);
        check("t1_latency", 64'(rsp_cyc - mvi_cyc), 64'd18);
        wait_idle();

        // Simultaneous 1 and 3 after reset
        do_reset(2);
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        push_rsp(1, 32'd63, 1'b0);
        push_rsp(3, 32'hFFFE0001, 1'b0);
        base = rsp_cnt;
        fork
            send(1, 16'd7, 16'd9);
            send(3, 16'hFFFF, 16'hFFFF);
        join
        wait_rsp(base + 2, 200);
        wait_idle();

        // All four requesting, requester 0 comes back for a second turn
        for (int i = 0; i < 4; i++) exp_grant.push_back(i);
        exp_grant.push_back(0);
        push_rsp(0, 32'd10, 1'b0);
        push_rsp(1, 32'd20, 1'b0);
        push_rsp(2, 32'd30, 1'b0);
        push_rsp(3, 32'd40, 1'b0);
        push_rsp(0, 32'd10, 1'b0);
        base = rsp_cnt;
        fork
            begin send(0, 16'd1, 16'd10); send(0, 16'd1, 16'd10); end
            send(1, 16'd2, 16'd10);
            send(2, 16'd3, 16'd10);
            send(3, 16'd4, 16'd10);
        join
        wait_rsp(base + 5, 400);
        wait_idle();

        // valid_out held for 3 cycles yields a single response
        mock_hold = 3;
        exp_grant.push_back(1);
        push_rsp(1, 32'd6, 1'b0);
        base = rsp_cnt;
        send(1, 16'd2, 16'd3);
        wait_rsp(base + 1, 200);
        tick(10);
        check("t4_single_rsp", 64'(rsp_cnt - base), 64'd1);
        wait_idle();

        // Level still high from the previous op must not complete the next one
        mock_hold = 40;
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        push_rsp(2, 32'd20, 1'b0);
        push_rsp(3, 32'd42, 1'b0);
        base = rsp_cnt;
        fork
            send(2, 16'd4, 16'd5);
            send(3, 16'd6, 16'd7);
        join
        wait_rsp(base + 1, 200);
        for (int c = 0; c < 200 && mul_valid_out; c++) tick(1);
        check("t4_no_rsp_on_held_level", 64'(rsp_cnt - base), 64'd1);
        wait_rsp(base + 2, 200);
        wait_idle();
        mock_hold = 1;

        // Reset in the middle of WAIT drops the operation
        exp_grant.push_back(0);
        send(0, 16'd9, 16'd9);
        tick(5);
        reset = 1'b0;
        @(negedge clk);
        check("t5_reset_ctrl_outputs",
              64'({req_ready, rsp_valid, rsp_id, rsp_error, busy, mul_valid_in}), 64'd0);
        check("t5_reset_data_outputs", {rsp_product, mul_in_a, mul_in_b}, 64'd0);
        tick(2);
        reset = 1'b1;
        base = rsp_cnt;
        tick(40);
        check("t5_no_rsp_after_reset", 64'(rsp_cnt - base), 64'd0);
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        push_rsp(0, 32'h00010000, 1'b0);
        push_rsp(1, 32'd0, 1'b0);
        fork
            send(1, 16'd0, 16'h1234);
            send(0, 16'h8000, 16'd2);
        join
        wait_rsp(base + 2, 200);
        wait_idle();

`ifdef BOOTH_ARB_TIMEOUT_EN
        // Multiplier never answers: watchdog response after 64 WAIT cycles
        mock_never = 1'b1;
        exp_grant.push_back(2);
        push_rsp(2, 32'd0, 1'b1);
        base = rsp_cnt;
        send(2, 16'd5, 16'd5);
        wait_rsp(base + 1, 300);
        check("t6_timeout_latency", 64'(rsp_cyc - mvi_cyc), 64'd65);
        wait_idle();
        mock_never = 1'b0;
`endif

        tick(5);
        check("scoreboard_rsp_drained", 64'(exp_rsp.size()), 64'd0);
        check("scoreboard_grant_drained", 64'(exp_grant.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
